// File: rtl/fetch_controller.sv
//------------------------------------------------------------------------------
// fetch_controller: instruction fetch sequencer with a 2-entry decode queue.
// Optional macro FETCH_BOUNDS_CHECK_EN: out-of-range fetches become faulting NOPs.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_controller #(
    parameter int                 XLEN      = 64,
    parameter logic [XLEN-1:0]    RESET_PC  = '0,
    parameter int                 MEM_BYTES = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            out_fault,
    output logic            busy
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            fault;
    } entry_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q,   req_pc_d;
    logic            req_fault_q, req_fault_d;
    logic            inflight_q, inflight_d;
    logic            frozen_q,   frozen_d;
    logic [1:0]      count_q,    count_d;
    entry_t          ent_q [2];
    entry_t          ent_d [2];

    logic            w_deq;
    logic            w_enq;
    logic            w_issue;
    logic            w_oob;
    logic [2:0]      w_occ;
    entry_t          w_new;
    logic [33:0]     w_unused_cfg;

`ifdef FETCH_BOUNDS_CHECK_EN
    assign w_oob = fetch_pc_q > (XLEN'(MEM_BYTES) - XLEN'(4));
`else
    assign w_oob = 1'b0;
`endif

    // Low redirect bits are forced to zero; MEM_BYTES only matters with bounds checking.
    assign w_unused_cfg = {redirect_pc[1:0], 32'(MEM_BYTES)};

    assign imem_addr = fetch_pc_q;
    assign out_valid = (count_q != 2'd0);
    assign out_pc    = ent_q[0].pc;
    assign out_instr = ent_q[0].instr;
    assign out_fault = ent_q[0].fault;
    assign busy      = (count_q != 2'd0) | inflight_q;

    always_comb begin
        w_deq   = out_valid & out_ready;
        w_enq   = inflight_q & ~redirect_valid;
        // Slots committed after this cycle: deq implies count>=1, so no underflow.
        w_occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_deq};
        w_issue = fetch_en & ~redirect_valid & ~frozen_q & (w_occ < 3'd2);

        w_new.pc    = req_pc_q;
        w_new.instr = req_fault_q ? NOP_INSTR : imem_instr;
        w_new.fault = req_fault_q;
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        req_fault_d = req_fault_q;
        inflight_d  = 1'b0;
        frozen_d    = frozen_q;

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            frozen_d   = 1'b0;
        end else if (w_issue) begin
            inflight_d  = 1'b1;
            req_pc_d    = fetch_pc_q;
            req_fault_d = w_oob;
            if (w_oob) begin
                frozen_d = 1'b1;
            end else begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
        end
    end

    // Head is always slot 0; a dequeue shifts slot 1 down before the tail write.
    always_comb begin
        ent_d   = ent_q;
        count_d = count_q;

        if (redirect_valid) begin
            count_d = 2'd0;
        end else begin
            if (w_deq) begin
                ent_d[0] = ent_q[1];
                count_d  = count_q - 2'd1;
            end
            if (w_enq) begin
                ent_d[count_d[0]] = w_new;
                count_d           = count_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= '0;
            req_fault_q <= 1'b0;
            inflight_q  <= 1'b0;
            frozen_q    <= 1'b0;
            count_q     <= 2'd0;
            ent_q[0]    <= '0;
            ent_q[1]    <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            req_fault_q <= req_fault_d;
            inflight_q  <= inflight_d;
            frozen_q    <= frozen_d;
            count_q     <= count_d;
            ent_q[0]    <= ent_d[0];
            ent_q[1]    <= ent_d[1];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_controller.sv
//------------------------------------------------------------------------------
// tb_fetch_controller: table-driven directed bench for fetch_controller.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr = '0;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;
    logic        busy;

    int n_vec  = 0;
    int n_miss = 0;

    fetch_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_fault      (out_fault),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // 1 KiB memory image: word i holds (i+1)*0x11, so 0..3 read 11,22,33,44.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (32'(a[9:2]) + 32'd1) * 32'h11;
    endfunction

    always @(posedge clk) imem_instr <= mem_word(imem_addr);

    typedef struct {
        bit          rst;
        bit          en;
        bit          rdy;
        bit          rv;
        logic [63:0] rpc;
        bit          ev;
        logic [63:0] epc;
        bit          ef;
        logic [63:0] eaddr;
        bit          eb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit en, bit rdy, bit rv, logic [63:0] rpc,
                                bit ev, logic [63:0] epc, bit ef, logic [63:0] eaddr, bit eb);
        vec_t v;
        v.rst = rst; v.en = en; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.ef = ef; v.eaddr = eaddr; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        //                 rst en rdy rv rpc       ev epc       ef addr      busy
        // Streaming from reset with decode always ready
        vecs.push_back(mk(1, 1, 1, 0, 64'h0,  0, 64'h0,  0, 64'h0,  0));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,  0, 64'h0,  0, 64'h4,  1));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,  1, 64'h0,  0, 64'h8,  1));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,  1, 64'h4,  0, 64'hC,  1));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,  1, 64'h8,  0, 64'h10, 1));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,  1, 64'hC,  0, 64'h14, 1));
        // Backpressure for 5 cycles, then redirects
        vecs.push_back(mk(1, 1, 0, 0, 64'h0,  0, 64'h0,  0, 64'h0,  0));
        vecs.push_back(mk(0, 1, 0, 0, 64'h0,  0, 64'h0,  0, 64'h4,  1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 1, 0, 0, 64'h0, 1, 64'h0, 0, 64'h8, 1));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,  1, 64'h0,  0, 64'h8,  1));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,  1, 64'h4,  0, 64'hC,  1));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,  1, 64'h8,  0, 64'h10, 1));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,  1, 64'hC,  0, 64'h14, 1));
        vecs.push_back(mk(0, 1, 0, 1, 64'h40, 1, 64'h10, 0, 64'h18, 1));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,  0, 64'h0,  0, 64'h40, 0));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,  0, 64'h0,  0, 64'h44, 1));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,  1, 64'h40, 0, 64'h48, 1));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,  1, 64'h44, 0, 64'h4C, 1));
        vecs.push_back(mk(0, 1, 1, 1, 64'h43, 1, 64'h48, 0, 64'h50, 1));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,  0, 64'h0,  0, 64'h40, 0));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,  0, 64'h0,  0, 64'h44, 1));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,  1, 64'h40, 0, 64'h48, 1));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,  1, 64'h44, 0, 64'h4C, 1));
        // fetch_en dropped after one issue, then resumed
        vecs.push_back(mk(1, 1, 1, 0, 64'h0,  0, 64'h0,  0, 64'h0,  0));
        vecs.push_back(mk(0, 0, 1, 0, 64'h0,  0, 64'h0,  0, 64'h4,  1));
        vecs.push_back(mk(0, 0, 1, 0, 64'h0,  1, 64'h0,  0, 64'h4,  1));
        vecs.push_back(mk(0, 0, 1, 0, 64'h0,  0, 64'h0,  0, 64'h4,  0));
        vecs.push_back(mk(0, 0, 1, 0, 64'h0,  0, 64'h0,  0, 64'h4,  0));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,  0, 64'h0,  0, 64'h4,  0));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,  0, 64'h0,  0, 64'h8,  1));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,  1, 64'h4,  0, 64'hC,  1));
`ifdef FETCH_BOUNDS_CHECK_EN
        // Run off the end of memory, freeze, then recover by redirect
        vecs.push_back(mk(1, 1, 1, 1, 64'h3FC, 0, 64'h0,   0, 64'h0,   0));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,   0, 64'h0,   0, 64'h3FC, 0));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,   0, 64'h0,   0, 64'h400, 1));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,   1, 64'h3FC, 0, 64'h400, 1));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,   1, 64'h400, 1, 64'h400, 1));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,   0, 64'h0,   0, 64'h400, 0));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,   0, 64'h0,   0, 64'h400, 0));
        vecs.push_back(mk(0, 1, 1, 1, 64'h0,   0, 64'h0,   0, 64'h400, 0));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,   0, 64'h0,   0, 64'h0,   0));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,   0, 64'h0,   0, 64'h4,   1));
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,   1, 64'h0,   0, 64'h8,   1));
`endif

        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (vecs[i].rst) rst_n = 1'b0;
            fetch_en       = vecs[i].en;
            out_ready      = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            #1;
            rst_n = 1'b1;
            #1;
            n_vec++;
            chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vecs[i].ev));
            chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].eaddr);
            chk($sformatf("v%0d busy", i), 64'(busy), 64'(vecs[i].eb));
            if (dut.count_q > 2'd2) begin
                n_miss++;
                $display("FAIL v%0d count: got %0d expected <=2", i, dut.count_q);
            end
            if (vecs[i].ev) begin
                chk($sformatf("v%0d out_pc", i), out_pc, vecs[i].epc);
                chk($sformatf("v%0d out_fault", i), 64'(out_fault), 64'(vecs[i].ef));
                chk($sformatf("v%0d out_instr", i), 64'(out_instr),
                    vecs[i].ef ? 64'h13 : 64'(mem_word(vecs[i].epc)));
            end
        end

        // Asynchronous reset in the middle of a running stream
        @(negedge clk);
        fetch_en       = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        chk("pre_rst out_valid", 64'(out_valid), 64'h1);
        chk("pre_rst busy", 64'(busy), 64'h1);
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        chk("async_rst out_valid", 64'(out_valid), 64'h0);
        chk("async_rst out_pc", out_pc, 64'h0);
        chk("async_rst out_instr", 64'(out_instr), 64'h0);
        chk("async_rst out_fault", 64'(out_fault), 64'h0);
        chk("async_rst busy", 64'(busy), 64'h0);
        chk("async_rst imem_addr", imem_addr, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_vec++;
            chk($sformatf("post_rst%0d imem_addr", k), imem_addr, 64'(4 * k));
            chk($sformatf("post_rst%0d out_valid", k), 64'(out_valid), (k >= 2) ? 64'h1 : 64'h0);
            if (k >= 2) begin
                chk($sformatf("post_rst%0d out_pc", k), out_pc, 64'(4 * (k - 2)));
                chk($sformatf("post_rst%0d out_instr", k), 64'(out_instr),
                    64'(mem_word(64'(4 * (k - 2)))));
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
